iact_stream_fetcher: RTL and testbench
======================================

Name: iact_stream_fetcher

Overview:
- Read-side consumer of the iact SRAM bank.
- On a start command, issues one read request (enable + base address) to the bank, accepts the bank's address stream and data stream through ready/valid handshakes, and buffers each in its own small FIFO.
- Forwards both streams, zero terminators included, to the PE-side iact ports. Reports completion once the bank signals read done and both FIFOs have drained.

Parameters:
ADDR_W, 7, width of iact address-stream entries
DATA_W, 12, width of iact data-stream entries
RADDR_W, 10, width of bank read start address
FIFO_DEPTH, 4, entries per stream FIFO; power of two, >=2

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request to fetch one iact stream pair
start_addr  in  RADDR_W  bank start address, sampled with start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when fetch completes
bank_read_en  out  1  read request to bank
bank_read_addr  out  RADDR_W  read start address to bank
bank_read_done  in  1  bank end-of-both-streams indication (one-cycle)
bank_addr_valid  in  1  bank address-stream valid
bank_addr_ready  out  1  fetcher can accept address entry
bank_addr  in  ADDR_W  address-stream entry
bank_data_valid  in  1  bank data-stream valid
bank_data_ready  out  1  fetcher can accept data entry
bank_data  in  DATA_W  data-stream entry
pe_addr_valid  out  1  address FIFO non-empty
pe_addr_ready  in  1  PE accepts address entry
pe_addr  out  ADDR_W  address FIFO head
pe_data_valid  out  1  data FIFO non-empty
pe_data_ready  in  1  PE accepts data entry
pe_data  out  DATA_W  data FIFO head

Behaviour:
- Reset (reset==0 at a clock edge) outputs: busy=0, done=0, bank_read_en=0, bank_read_addr=0, bank_addr_ready=0, bank_data_ready=0, pe_addr_valid=0, pe_data_valid=0, pe_addr=0, pe_data=0.
- Reset, internal: state=IDLE; FIFO pointers and counters cleared; read-done latch cleared.
- Reset mid-operation discards all buffered entries. No done pulse is produced.
- FSM states: IDLE, REQ, STREAM, DRAIN, FIN.
- IDLE:
  - start=1: latch start_addr, go to REQ.
  - start is ignored in every other state.
- REQ (exactly 1 cycle):
  - bank_read_en=1 and bank_read_addr=latched address; bank_read_en is 0 in every other state.
  - Next state: STREAM.
- STREAM:
  - bank_addr_ready = !addr_fifo_full; bank_data_ready = !data_fifo_full.
  - Push a FIFO on valid&ready. Pop on pe_*_valid&pe_*_ready.
  - Push and pop in the same cycle are legal at any occupancy except a push into a full FIFO, which is prevented because ready is based on full only.
  - bank_read_done=1: set done latch, go to DRAIN.
  - Entries handshaken in the same cycle as bank_read_done are still pushed.
- DRAIN:
  - bank_*_ready=0; PE pops continue.
  - Both FIFOs empty: go to FIN.
- FIN:
  - done=1 for one cycle, busy drops in the same cycle, next state IDLE.
  - A start in FIN is ignored.
- busy=1 in REQ, STREAM, DRAIN and FIN, with the exception noted above: it is 0 during the done cycle.
- bank_*_ready=0 in IDLE, REQ, DRAIN and FIN.
- FIFO behaviour:
  - Synchronous circular buffers; pointers wrap modulo FIFO_DEPTH.
  - Full/empty come from a log2(FIFO_DEPTH)+1-bit occupancy count.
  - pe_* outputs show the head entry combinationally from storage (zero added latency beyond the write edge).
  - First-word latency: bank entry accepted at edge N is visible on pe_* after edge N.
- bank_read_done arriving in IDLE or REQ is ignored.
- Values are passed through unmodified. Zero entries are ordinary entries; the terminator is forwarded to the PE.

Optional Feature:
- Macro IACT_FETCH_CNT_EN.
- Defined:
  - Adds outputs addr_count (8b) and data_count (8b).
  - Each counter counts entries popped to the PE since the last accepted start. Both are cleared on the REQ cycle and saturate at 255.
  - Values hold after done until the next start.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Basic fetch: start=1, start_addr=0x010; bank sends addr {3,5,0}, data {0x0A1,0x0B2,0x0C3,0x000}; read_done with last entry; pe_ready=1 -> bank_read_en=1 for exactly one cycle with addr 0x010; PE receives all 7 entries in order; done pulses 1 cycle after FIFOs empty (count option: addr_count=3, data_count=4).
- Backpressure: pe_addr_ready=0, bank sends 6 address entries -> bank_addr_ready drops after 4 pushes; no entry lost or duplicated once pe_addr_ready=1.
- Wrap-around: 10 data entries with pe_data_ready toggling every cycle -> output order exact; pointers wrap twice; no spurious pe_data_valid.
- Start ignored: second start with start_addr=0x020 during STREAM -> bank_read_addr stays 0x010; only one done.
- Reset mid-stream: reset=0 after 2 of 5 entries pushed -> next cycle all valids 0, busy=0, FIFOs empty; a new start then fetches cleanly.
- Early done: bank_read_done asserted in IDLE -> no state change, no done.

Source files
------------

// File: rtl/iact_stream_fetcher.sv
// rtl/iact_stream_fetcher.sv - iact SRAM bank read-side stream fetcher
//
// Issues one read request to the iact bank for each accepted start, then
// buffers the bank's address and data streams in two small FIFOs. Both
// streams go to the PE ports unmodified, zero terminators included. done
// pulses once the bank has reported end of read and both FIFOs are empty.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-low reset
//   start, start_addr             fetch request and bank start address
//   busy, done                    fetch in progress / one-cycle completion pulse
//   bank_read_en, bank_read_addr  one-cycle read request to the bank
//   bank_read_done                bank end-of-both-streams pulse
//   bank_addr_* / bank_data_*     bank-side ready/valid streams
//   pe_addr_* / pe_data_*         PE-side ready/valid streams (FIFO heads)
//   addr_count, data_count        entries popped to the PE since the last start
//                                 (present only when IACT_FETCH_CNT_EN is defined)
module iact_stream_fetcher #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 12,
    parameter int RADDR_W    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [RADDR_W-1:0] start_addr,
    output logic               busy,
    output logic               done,
    output logic               bank_read_en,
    output logic [RADDR_W-1:0] bank_read_addr,
    input  logic               bank_read_done,
    input  logic               bank_addr_valid,
    output logic               bank_addr_ready,
    input  logic [ADDR_W-1:0]  bank_addr,
    input  logic               bank_data_valid,
    output logic               bank_data_ready,
    input  logic [DATA_W-1:0]  bank_data,
    output logic               pe_addr_valid,
    input  logic               pe_addr_ready,
    output logic [ADDR_W-1:0]  pe_addr,
    output logic               pe_data_valid,
    input  logic               pe_data_ready,
    output logic [DATA_W-1:0]  pe_data
`ifdef IACT_FETCH_CNT_EN
    ,
    output logic [7:0]         addr_count,
    output logic [7:0]         data_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, STREAM, DRAIN, FIN} state_t;

    state_t             state, state_next;
    logic [RADDR_W-1:0] addr_reg;
    logic               read_done_seen;

    logic [ADDR_W-1:0]  a_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   a_wr, a_rd;
    logic [CNT_W-1:0]   a_cnt;
    logic               a_full, a_empty, a_push, a_pop;

    logic [DATA_W-1:0]  d_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   d_wr, d_rd;
    logic [CNT_W-1:0]   d_cnt;
    logic               d_full, d_empty, d_push, d_pop;

    assign a_full  = (a_cnt == FULL_CNT);
    assign a_empty = (a_cnt == '0);
    assign d_full  = (d_cnt == FULL_CNT);
    assign d_empty = (d_cnt == '0);

    // Ready depends on full only, so a push never lands on a full FIFO even
    // when the PE pops in the same cycle.
    assign bank_addr_ready = (state == STREAM) && !a_full;
    assign bank_data_ready = (state == STREAM) && !d_full;
    assign a_push = bank_addr_valid && bank_addr_ready;
    assign d_push = bank_data_valid && bank_data_ready;
    assign a_pop  = !a_empty && pe_addr_ready;
    assign d_pop  = !d_empty && pe_data_ready;

    // Head is forced to zero while empty so stale storage never shows.
    assign pe_addr_valid = !a_empty;
    assign pe_data_valid = !d_empty;
    assign pe_addr       = a_empty ? '0 : a_mem[a_rd];
    assign pe_data       = d_empty ? '0 : d_mem[d_rd];

    assign bank_read_addr = addr_reg;

    always_ff @(posedge clock) begin
        if (a_push) a_mem[a_wr] <= bank_addr;
        if (d_push) d_mem[d_wr] <= bank_data;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            a_wr  <= '0;
            a_rd  <= '0;
            a_cnt <= '0;
            d_wr  <= '0;
            d_rd  <= '0;
            d_cnt <= '0;
        end else begin
            if (a_push) a_wr <= a_wr + 1'b1;
            if (a_pop)  a_rd <= a_rd + 1'b1;
            a_cnt <= a_cnt + CNT_W'(a_push) - CNT_W'(a_pop);
            if (d_push) d_wr <= d_wr + 1'b1;
            if (d_pop)  d_rd <= d_rd + 1'b1;
            d_cnt <= d_cnt + CNT_W'(d_push) - CNT_W'(d_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            addr_reg       <= '0;
            read_done_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) addr_reg <= start_addr;
            if (state == REQ) begin
                read_done_seen <= 1'b0;
            end else if (state == STREAM && bank_read_done) begin
                read_done_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        done         = 1'b0;
        bank_read_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = REQ;
            end
            REQ: begin
                busy         = 1'b1;
                bank_read_en = 1'b1;
                state_next   = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (bank_read_done) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (read_done_seen && a_empty && d_empty) state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef IACT_FETCH_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_count <= '0;
            data_count <= '0;
        end else if (state == REQ) begin
            addr_count <= '0;
            data_count <= '0;
        end else begin
            if (a_pop && addr_count != 8'hFF) addr_count <= addr_count + 8'd1;
            if (d_pop && data_count != 8'hFF) data_count <= data_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iact_stream_fetcher.sv
// tb/tb_iact_stream_fetcher.sv - self-checking bench for iact_stream_fetcher
module tb_iact_stream_fetcher;

    logic        clock = 1'b0;
    logic        reset, start, bank_read_done;
    logic [9:0]  start_addr;
    logic        busy, done, bank_read_en;
    logic [9:0]  bank_read_addr;
    logic        bank_addr_valid, bank_addr_ready, bank_data_valid, bank_data_ready;
    logic [6:0]  bank_addr, pe_addr;
    logic [11:0] bank_data, pe_data;
    logic        pe_addr_valid, pe_addr_ready, pe_data_valid, pe_data_ready;
`ifdef IACT_FETCH_CNT_EN
    logic [7:0]  addr_count, data_count;
`endif

    always #5 clock = ~clock;

    iact_stream_fetcher dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .busy(busy), .done(done), .bank_read_en(bank_read_en),
        .bank_read_addr(bank_read_addr), .bank_read_done(bank_read_done),
        .bank_addr_valid(bank_addr_valid), .bank_addr_ready(bank_addr_ready),
        .bank_addr(bank_addr), .bank_data_valid(bank_data_valid),
        .bank_data_ready(bank_data_ready), .bank_data(bank_data),
        .pe_addr_valid(pe_addr_valid), .pe_addr_ready(pe_addr_ready), .pe_addr(pe_addr),
        .pe_data_valid(pe_data_valid), .pe_data_ready(pe_data_ready), .pe_data(pe_data)
`ifdef IACT_FETCH_CNT_EN
        , .addr_count(addr_count), .data_count(data_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 request, 2 streaming, 3 draining, 4 finished.
    int         m_phase;
    logic [9:0] m_lat;
    logic [6:0] m_aq[$];
    logic [11:0] m_dq[$];
    int         m_ca, m_cd;

    task automatic model_reset();
        m_phase = 0; m_lat = '0; m_aq.delete(); m_dq.delete(); m_ca = 0; m_cd = 0;
    endtask

    task automatic model_advance();
        int  ph;
        bit  a_room, d_room, both_empty;
        if (!reset) begin
            model_reset();
            return;
        end
        ph         = m_phase;
        a_room     = (ph == 2) && (m_aq.size() < 4);
        d_room     = (ph == 2) && (m_dq.size() < 4);
        both_empty = (m_aq.size() == 0) && (m_dq.size() == 0);
        if (ph == 1) begin
            m_ca = 0; m_cd = 0;
        end
        if (m_aq.size() > 0 && pe_addr_ready) begin
            void'(m_aq.pop_front());
            if (ph != 1 && m_ca < 255) m_ca++;
        end
        if (m_dq.size() > 0 && pe_data_ready) begin
            void'(m_dq.pop_front());
            if (ph != 1 && m_cd < 255) m_cd++;
        end
        if (a_room && bank_addr_valid) m_aq.push_back(bank_addr);
        if (d_room && bank_data_valid) m_dq.push_back(bank_data);
        case (ph)
            0: if (start) begin m_phase = 1; m_lat = start_addr; end
            1: m_phase = 2;
            2: if (bank_read_done) m_phase = 3;
            3: if (both_empty) m_phase = 4;
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare();
        chk("busy", busy, (m_phase >= 1 && m_phase <= 3));
        chk("done", done, (m_phase == 4));
        chk("bank_read_en", bank_read_en, (m_phase == 1));
        chk("bank_read_addr", bank_read_addr, m_lat);
        chk("bank_addr_ready", bank_addr_ready, (m_phase == 2 && m_aq.size() < 4));
        chk("bank_data_ready", bank_data_ready, (m_phase == 2 && m_dq.size() < 4));
        chk("pe_addr_valid", pe_addr_valid, (m_aq.size() > 0));
        chk("pe_data_valid", pe_data_valid, (m_dq.size() > 0));
        chk("pe_addr", pe_addr, (m_aq.size() > 0) ? m_aq[0] : 7'd0);
        chk("pe_data", pe_data, (m_dq.size() > 0) ? m_dq[0] : 12'd0);
`ifdef IACT_FETCH_CNT_EN
        chk("addr_count", addr_count, m_ca);
        chk("data_count", data_count, m_cd);
`endif
    endtask

    task automatic cycle();
        model_advance();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic quiet();
        start = 0; start_addr = '0; bank_read_done = 0;
        bank_addr_valid = 0; bank_addr = '0; bank_data_valid = 0; bank_data = '0;
        pe_addr_ready = 0; pe_data_ready = 0;
    endtask

    typedef struct {
        logic        start;
        logic [9:0]  saddr;
        logic        rd, av;
        logic [6:0]  a;
        logic        dv;
        logic [11:0] d;
        logic        par, pdr;
        logic        e_busy, e_done, e_ren, e_pav;
        logic [6:0]  e_pa;
        logic        e_pdv;
        logic [11:0] e_pd;
    } vec_t;

    vec_t tbl[9];

    function automatic bit ready_mode(input int mode, input int i);
        case (mode)
            0: return 1'b1;
            1: return i[0];
            2: return 1'($urandom % 2);
            default: return (i >= 10);
        endcase
    endfunction

    task automatic run_fetch(input logic [9:0] sa, input int na, input int nd,
                             input int amode, input int dmode, input bit inj_start);
        logic [6:0]  src_a[$], exp_a[$], rx_a[$];
        logic [11:0] src_d[$], exp_d[$], rx_d[$];
        int ndone = 0;
        bit rd_sent = 0;
        bit ta, td;
        for (int i = 0; i < na; i++) begin
            logic [6:0] v;
            v = (i == na - 1) ? 7'd0 : 7'($urandom_range(1, 127));
            src_a.push_back(v); exp_a.push_back(v);
        end
        for (int i = 0; i < nd; i++) begin
            logic [11:0] v;
            v = (i == nd - 1) ? 12'd0 : 12'($urandom_range(1, 4095));
            src_d.push_back(v); exp_d.push_back(v);
        end
        quiet();
        start = 1; start_addr = sa;
        cycle();
        start = 0;
        cycle();
        for (int i = 0; i < 400 && ndone == 0; i++) begin
            bank_addr_valid = (src_a.size() > 0);
            bank_addr       = (src_a.size() > 0) ? src_a[0] : 7'd0;
            bank_data_valid = (src_d.size() > 0);
            bank_data       = (src_d.size() > 0) ? src_d[0] : 12'd0;
            bank_read_done  = !rd_sent && src_a.size() == 0 && src_d.size() == 0;
            pe_addr_ready   = ready_mode(amode, i);
            pe_data_ready   = ready_mode(dmode, i);
            start           = inj_start && (i == 3);
            start_addr      = inj_start ? 10'h020 : sa;
            if (amode == 3 && i == 8) chk("backpressure_addr_ready_low", bank_addr_ready, 0);
            ta = bank_addr_valid && bank_addr_ready;
            td = bank_data_valid && bank_data_ready;
            if (pe_addr_valid && pe_addr_ready) rx_a.push_back(pe_addr);
            if (pe_data_valid && pe_data_ready) rx_d.push_back(pe_data);
            if (bank_read_done) rd_sent = 1;
            cycle();
            if (ta) void'(src_a.pop_front());
            if (td) void'(src_d.pop_front());
            if (done) ndone++;
        end
        quiet();
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (done) ndone++;
        end
        chk("fetch_done_pulses", ndone, 1);
        chk("rx_addr_len", rx_a.size(), na);
        chk("rx_data_len", rx_d.size(), nd);
        for (int i = 0; i < na && i < rx_a.size(); i++) chk("rx_addr_order", rx_a[i], exp_a[i]);
        for (int i = 0; i < nd && i < rx_d.size(); i++) chk("rx_data_order", rx_d[i], exp_d[i]);
        if (inj_start) chk("start_ignored_addr", bank_read_addr, sa);
    endtask

    initial begin
        quiet();
        model_reset();
        reset = 0;
        cycle();
        cycle();
        reset = 1;
        cycle();

        // Basic fetch: three address entries, four data entries, done with the last one.
        tbl[0] = '{1'b1, 10'h010, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000, 1'b1, 1'b1,
                   1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 12'h000};
        tbl[1] = '{1'b0, 10'h000, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000, 1'b1, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000};
        tbl[2] = '{1'b0, 10'h000, 1'b0, 1'b1, 7'd3, 1'b1, 12'h0A1, 1'b1, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b1, 7'd3, 1'b1, 12'h0A1};
        tbl[3] = '{1'b0, 10'h000, 1'b0, 1'b1, 7'd5, 1'b1, 12'h0B2, 1'b1, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b1, 7'd5, 1'b1, 12'h0B2};
        tbl[4] = '{1'b0, 10'h000, 1'b0, 1'b1, 7'd0, 1'b1, 12'h0C3, 1'b1, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 1'b1, 12'h0C3};
        tbl[5] = '{1'b0, 10'h000, 1'b1, 1'b0, 7'd0, 1'b1, 12'h000, 1'b1, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 12'h000};
        tbl[6] = '{1'b0, 10'h000, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000, 1'b1, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000};
        tbl[7] = '{1'b0, 10'h000, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000, 1'b1, 1'b1,
                   1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000};
        tbl[8] = '{1'b0, 10'h000, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000, 1'b1, 1'b1,
                   1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000};
        for (int i = 0; i < 9; i++) begin
            start = tbl[i].start; start_addr = tbl[i].saddr; bank_read_done = tbl[i].rd;
            bank_addr_valid = tbl[i].av; bank_addr = tbl[i].a;
            bank_data_valid = tbl[i].dv; bank_data = tbl[i].d;
            pe_addr_ready = tbl[i].par; pe_data_ready = tbl[i].pdr;
            cycle();
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_done", done, tbl[i].e_done);
            chk("tbl_read_en", bank_read_en, tbl[i].e_ren);
            chk("tbl_pe_addr_valid", pe_addr_valid, tbl[i].e_pav);
            chk("tbl_pe_addr", pe_addr, tbl[i].e_pa);
            chk("tbl_pe_data_valid", pe_data_valid, tbl[i].e_pdv);
            chk("tbl_pe_data", pe_data, tbl[i].e_pd);
            if (i == 0) chk("tbl_read_addr", bank_read_addr, 10'h010);
        end
        quiet();

        // Backpressure, wrap-around, start ignored mid-stream.
        run_fetch(10'h011, 6, 2, 3, 0, 1'b0);
        run_fetch(10'h012, 2, 10, 0, 1, 1'b0);
        run_fetch(10'h010, 4, 5, 2, 2, 1'b1);

        // Reset mid-stream after two pushes.
        quiet();
        start = 1; start_addr = 10'h030;
        cycle();
        start = 0;
        cycle();
        bank_addr_valid = 1; bank_addr = 7'd11; bank_data_valid = 1; bank_data = 12'h111;
        cycle();
        bank_addr = 7'd12; bank_data = 12'h222;
        cycle();
        quiet();
        reset = 0;
        cycle();
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pe_addr_valid", pe_addr_valid, 0);
        chk("rst_mid_pe_data_valid", pe_data_valid, 0);
        chk("rst_mid_done", done, 0);
        reset = 1;
        cycle();
        run_fetch(10'h040, 3, 3, 0, 0, 1'b0);

        // bank_read_done in IDLE, then in REQ: both ignored.
        quiet();
        bank_read_done = 1;
        cycle();
        chk("early_done_idle_busy", busy, 0);
        chk("early_done_idle_done", done, 0);
        bank_read_done = 0;
        cycle();
        chk("early_done_idle_done2", done, 0);
        start = 1; start_addr = 10'h055;
        cycle();
        start = 0; bank_read_done = 1;
        cycle();
        bank_read_done = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("early_done_req_still_busy", busy, 1);
        bank_read_done = 1;
        cycle();
        bank_read_done = 0;
        cycle();
        chk("early_done_req_final_done", done, 1);
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset           = ($urandom % 100) != 0;
            start           = ($urandom % 20) == 0;
            start_addr      = 10'($urandom);
            bank_read_done  = ($urandom % 16) == 0;
            bank_addr_valid = 1'($urandom % 2);
            bank_addr       = 7'($urandom);
            bank_data_valid = 1'($urandom % 2);
            bank_data       = 12'($urandom);
            pe_addr_ready   = 1'($urandom % 2);
            pe_data_ready   = 1'($urandom % 2);
            cycle();
        end
        quiet();
        reset = 1;
        pe_addr_ready = 1; pe_data_ready = 1; bank_read_done = 1;
        for (int i = 0; i < 10; i++) cycle();
        quiet();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
